// File: rtl/usb_hid_pkg.sv
// Shared types, constants and decode helpers for the USB HID report decoder.
package usb_hid_pkg;

    typedef enum logic [1:0] {
        DEV_NONE     = 2'd0,
        DEV_KEYBOARD = 2'd1,
        DEV_MOUSE    = 2'd2,
        DEV_GAMEPAD  = 2'd3
    } dev_typ_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RECV    = 2'd1,
        ST_PUBLISH = 2'd2
    } rpt_state_e;

    localparam logic [3:0] MIN_LEN_KEYBOARD = 4'd6;
    localparam logic [3:0] MIN_LEN_MOUSE    = 4'd3;
    localparam logic [3:0] MIN_LEN_GAMEPAD  = 4'd7;
    localparam logic [3:0] RPT_IDX_MAX      = 4'd8;

    localparam int GP_X_BYTE     = 0;
    localparam int GP_Y_BYTE     = 1;
    localparam int GP_BTN_BYTE   = 5;
    localparam int GP_BTN_A_BIT  = 4;
    localparam int GP_SYS_BYTE   = 6;
    localparam int GP_SEL_BIT    = 4;
    localparam int GP_STA_BIT    = 5;

    localparam logic [7:0] AXIS_LO = 8'h40;
    localparam logic [7:0] AXIS_HI = 8'hBF;

    typedef struct packed {
        logic [7:0] key_modifiers;
        logic [7:0] key1;
        logic [7:0] key2;
        logic [7:0] key3;
        logic [7:0] key4;
        logic [7:0] mouse_btn;
        logic [7:0] mouse_dx;
        logic [7:0] mouse_dy;
        logic       game_l;
        logic       game_r;
        logic       game_u;
        logic       game_d;
        logic       game_a;
        logic       game_b;
        logic       game_x;
        logic       game_y;
        logic       game_sel;
        logic       game_sta;
    } hid_fields_t;

    function automatic logic [7:0] rpt_byte(input logic [63:0] rpt, input int idx);
        return rpt[8*idx +: 8];
    endfunction

    function automatic logic rpt_len_ok(input dev_typ_e typ, input logic [3:0] len,
                                        input logic gamepad_en);
        case (typ)
            DEV_KEYBOARD: return len >= MIN_LEN_KEYBOARD;
            DEV_MOUSE:    return len >= MIN_LEN_MOUSE;
            DEV_GAMEPAD:  return gamepad_en && (len >= MIN_LEN_GAMEPAD);
            default:      return 1'b0;
        endcase
    endfunction

    // Axes are unsigned with 0x80 as centre; the dead band sits between the thresholds.
    function automatic hid_fields_t gp_decode(input logic [63:0] rpt);
        hid_fields_t f;
        logic [7:0]  btn;
        logic [7:0]  sys;
        f        = '0;
        btn      = rpt_byte(rpt, GP_BTN_BYTE);
        sys      = rpt_byte(rpt, GP_SYS_BYTE);
        f.game_l = rpt_byte(rpt, GP_X_BYTE) < AXIS_LO;
        f.game_r = rpt_byte(rpt, GP_X_BYTE) > AXIS_HI;
        f.game_u = rpt_byte(rpt, GP_Y_BYTE) < AXIS_LO;
        f.game_d = rpt_byte(rpt, GP_Y_BYTE) > AXIS_HI;
        f.game_a = btn[GP_BTN_A_BIT];
        f.game_b = btn[GP_BTN_A_BIT + 1];
        f.game_x = btn[GP_BTN_A_BIT + 2];
        f.game_y = btn[GP_BTN_A_BIT + 3];
        f.game_sel = sys[GP_SEL_BIT];
        f.game_sta = sys[GP_STA_BIT];
        return f;
    endfunction

endpackage

// File: rtl/usb_hid_led_req.sv
// LED update handshake: holds led_req until led_done or timeout, then pulses the ack.
module usb_hid_led_req
    import usb_hid_pkg::*;
#(
    parameter logic [23:0] LED_TIMEOUT_CYCLES = 24'd12_000_000
) (
    input  logic       usb_clk,
    input  logic       usb_rst_n,
    input  logic       update_leds_stb,
    input  logic [3:0] leds,
    input  logic [1:0] dev_typ,
    input  logic       led_done,
    output logic       led_req,
    output logic [7:0] led_data,
    output logic       ack_update_leds_stb
);

    logic        req_reg, req_next;
    logic [7:0]  data_reg, data_next;
    logic [23:0] cnt_reg, cnt_next;
    logic        ack_reg, ack_next;
    logic        finish;

    assign finish = req_reg && (led_done || (cnt_reg == LED_TIMEOUT_CYCLES - 24'd1));

    // A new strobe while pending restarts the wait; the single ack covers both requests.
    always_comb begin
        req_next  = req_reg;
        data_next = data_reg;
        cnt_next  = cnt_reg;
        ack_next  = finish;
        if (req_reg) begin
            cnt_next = cnt_reg + 24'd1;
        end
        if (finish) begin
            req_next = 1'b0;
        end
        if (update_leds_stb) begin
            if (dev_typ_e'(dev_typ) == DEV_KEYBOARD) begin
                req_next  = 1'b1;
                data_next = {4'h0, leds};
                cnt_next  = '0;
            end else begin
                ack_next = 1'b1;
            end
        end
    end

    always_ff @(posedge usb_clk) begin
        if (!usb_rst_n) begin
            req_reg  <= 1'b0;
            data_reg <= 8'h00;
            cnt_reg  <= '0;
            ack_reg  <= 1'b0;
        end else begin
            req_reg  <= req_next;
            data_reg <= data_next;
            cnt_reg  <= cnt_next;
            ack_reg  <= ack_next;
        end
    end

    assign led_req             = req_reg;
    assign led_data            = data_reg;
    assign ack_update_leds_stb = ack_reg;

endmodule

// File: rtl/usb_hid_report_decoder.sv
// Collects HID IN reports, decodes them per device type and publishes fields with a strobe.
// Define USB_HID_GAMEPAD_EN to build gamepad decode; otherwise gamepad reports are discarded.
module usb_hid_report_decoder
    import usb_hid_pkg::*;
#(
    parameter logic [23:0] LED_TIMEOUT_CYCLES = 24'd12_000_000
) (
    input  logic              usb_clk,
    input  logic              usb_rst_n,
    input  logic              rpt_valid,
    input  logic [7:0]        rpt_data,
    input  logic              rpt_last,
    input  logic              rpt_err,
    input  logic [1:0]        dev_typ,
    input  logic              dev_conn_err,
    output logic [1:0]        usb_typ,
    output logic              usb_conn_err,
    output logic              usb_report_stb,
    output logic [7:0]        usb_key_modifiers,
    output logic [7:0]        usb_key1,
    output logic [7:0]        usb_key2,
    output logic [7:0]        usb_key3,
    output logic [7:0]        usb_key4,
    output logic [7:0]        usb_mouse_btn,
    output logic signed [7:0] usb_mouse_dx,
    output logic signed [7:0] usb_mouse_dy,
    output logic              usb_game_l,
    output logic              usb_game_r,
    output logic              usb_game_u,
    output logic              usb_game_d,
    output logic              usb_game_a,
    output logic              usb_game_b,
    output logic              usb_game_x,
    output logic              usb_game_y,
    output logic              usb_game_sel,
    output logic              usb_game_sta,
    output logic [63:0]       usb_dbg_hid_report,
    input  logic              update_leds_stb,
    input  logic [3:0]        leds,
    output logic              led_req,
    output logic [7:0]        led_data,
    input  logic              led_done,
    output logic              ack_update_leds_stb
);

`ifdef USB_HID_GAMEPAD_EN
    localparam logic GAMEPAD_EN = 1'b1;
`else
    localparam logic GAMEPAD_EN = 1'b0;
`endif

    rpt_state_e  state_reg, state_next;
    logic [3:0]  idx_reg, idx_next;
    logic [7:0]  buf_reg  [8];
    logic [7:0]  buf_next [8];
    logic [63:0] buf_flat;
    logic [3:0]  wr_idx;
    logic        start_new, byte_wr, rpt_done, len_ok;
    logic        rpt_pub, sts_pub;

    hid_fields_t fields_dec, fields_reg;
    logic [63:0] dbg_reg;
    logic        stb_reg;
    logic [1:0]  typ_reg;
    logic        conn_err_reg;

    // Any byte outside RECV opens a fresh report, including the PUBLISH cycle.
    assign start_new = rpt_valid && (state_reg != ST_RECV);
    assign byte_wr   = start_new || ((state_reg == ST_RECV) && rpt_valid && !rpt_err);
    assign wr_idx    = start_new ? 4'd0 : idx_reg;
    assign rpt_done  = byte_wr && rpt_last;
    assign idx_next  = start_new ? 4'd1 :
                       (byte_wr && (idx_reg < RPT_IDX_MAX)) ? idx_reg + 4'd1 : idx_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_rpt_byte
            assign buf_next[gi] = start_new ? ((gi == 0) ? rpt_data : 8'h00) :
                                  (byte_wr && (wr_idx == 4'(gi))) ? rpt_data : buf_reg[gi];
            assign buf_flat[8*gi +: 8] = buf_next[gi];

            always_ff @(posedge usb_clk) begin
                if (!usb_rst_n) begin
                    buf_reg[gi] <= 8'h00;
                end else begin
                    buf_reg[gi] <= buf_next[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge usb_clk) begin
        if (!usb_rst_n) begin
            state_reg <= ST_IDLE;
            idx_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_RECV: begin
                if (rpt_err) begin
                    state_next = ST_IDLE;
                end else if (rpt_valid && rpt_last) begin
                    state_next = ST_PUBLISH;
                end
            end
            default: begin
                if (rpt_valid) begin
                    state_next = rpt_last ? ST_PUBLISH : ST_RECV;
                end else begin
                    state_next = ST_IDLE;
                end
            end
        endcase
    end

    // Status publish waits for a cycle that settles in IDLE and carries no report publish.
    always_comb begin
        rpt_pub = 1'b0;
        sts_pub = 1'b0;
        len_ok  = rpt_len_ok(dev_typ_e'(dev_typ), idx_next, GAMEPAD_EN);
        if (rpt_done && len_ok) begin
            rpt_pub = 1'b1;
        end else if ((state_next == ST_IDLE) &&
                     ({dev_typ, dev_conn_err} != {typ_reg, conn_err_reg})) begin
            sts_pub = 1'b1;
        end
    end

    always_comb begin
        fields_dec = '0;
        case (dev_typ_e'(dev_typ))
            DEV_KEYBOARD: begin
                fields_dec.key_modifiers = rpt_byte(buf_flat, 0);
                fields_dec.key1          = rpt_byte(buf_flat, 2);
                fields_dec.key2          = rpt_byte(buf_flat, 3);
                fields_dec.key3          = rpt_byte(buf_flat, 4);
                fields_dec.key4          = rpt_byte(buf_flat, 5);
            end
            DEV_MOUSE: begin
                fields_dec.mouse_btn = rpt_byte(buf_flat, 0);
                fields_dec.mouse_dx  = rpt_byte(buf_flat, 1);
                fields_dec.mouse_dy  = rpt_byte(buf_flat, 2);
            end
`ifdef USB_HID_GAMEPAD_EN
            DEV_GAMEPAD: begin
                fields_dec = gp_decode(buf_flat);
            end
`endif
            default: begin
                fields_dec = '0;
            end
        endcase
    end

    always_ff @(posedge usb_clk) begin
        if (!usb_rst_n) begin
            stb_reg      <= 1'b0;
            fields_reg   <= '0;
            dbg_reg      <= '0;
            typ_reg      <= 2'd0;
            conn_err_reg <= 1'b0;
        end else begin
            stb_reg <= rpt_pub || sts_pub;
            if (rpt_pub) begin
                fields_reg <= fields_dec;
                dbg_reg    <= buf_flat;
            end else if (sts_pub) begin
                fields_reg   <= '0;
                dbg_reg      <= '0;
                typ_reg      <= dev_typ;
                conn_err_reg <= dev_conn_err;
            end
        end
    end

    assign usb_report_stb     = stb_reg;
    assign usb_typ            = typ_reg;
    assign usb_conn_err       = conn_err_reg;
    assign usb_dbg_hid_report = dbg_reg;
    assign usb_key_modifiers  = fields_reg.key_modifiers;
    assign usb_key1           = fields_reg.key1;
    assign usb_key2           = fields_reg.key2;
    assign usb_key3           = fields_reg.key3;
    assign usb_key4           = fields_reg.key4;
    assign usb_mouse_btn      = fields_reg.mouse_btn;
    assign usb_mouse_dx       = fields_reg.mouse_dx;
    assign usb_mouse_dy       = fields_reg.mouse_dy;
    assign usb_game_l         = fields_reg.game_l;
    assign usb_game_r         = fields_reg.game_r;
    assign usb_game_u         = fields_reg.game_u;
    assign usb_game_d         = fields_reg.game_d;
    assign usb_game_a         = fields_reg.game_a;
    assign usb_game_b         = fields_reg.game_b;
    assign usb_game_x         = fields_reg.game_x;
    assign usb_game_y         = fields_reg.game_y;
    assign usb_game_sel       = fields_reg.game_sel;
    assign usb_game_sta       = fields_reg.game_sta;

    usb_hid_led_req #(
        .LED_TIMEOUT_CYCLES (LED_TIMEOUT_CYCLES)
    ) u_led_req (
        .usb_clk             (usb_clk),
        .usb_rst_n           (usb_rst_n),
        .update_leds_stb     (update_leds_stb),
        .leds                (leds),
        .dev_typ             (dev_typ),
        .led_done            (led_done),
        .led_req             (led_req),
        .led_data            (led_data),
        .ack_update_leds_stb (ack_update_leds_stb)
    );

endmodule

// File: tb/tb_usb_hid_report_decoder.sv
// Testbench for usb_hid_report_decoder: scoreboarded report/status strobes plus LED handshake.
module tb_usb_hid_report_decoder;

    localparam logic [23:0] TMO = 24'd16;

    logic              usb_clk = 1'b0;
    logic              usb_rst_n = 1'b0;
    logic              rpt_valid = 1'b0;
    logic [7:0]        rpt_data = 8'h00;
    logic              rpt_last = 1'b0;
    logic              rpt_err = 1'b0;
    logic [1:0]        dev_typ = 2'd1;
    logic              dev_conn_err = 1'b0;
    logic [1:0]        usb_typ;
    logic              usb_conn_err;
    logic              usb_report_stb;
    logic [7:0]        usb_key_modifiers, usb_key1, usb_key2, usb_key3, usb_key4;
    logic [7:0]        usb_mouse_btn;
    logic signed [7:0] usb_mouse_dx, usb_mouse_dy;
    logic              usb_game_l, usb_game_r, usb_game_u, usb_game_d;
    logic              usb_game_a, usb_game_b, usb_game_x, usb_game_y;
    logic              usb_game_sel, usb_game_sta;
    logic [63:0]       usb_dbg_hid_report;
    logic              update_leds_stb = 1'b0;
    logic [3:0]        leds = 4'h0;
    logic              led_req;
    logic [7:0]        led_data;
    logic              led_done = 1'b0;
    logic              ack_update_leds_stb;

    typedef struct packed {
        logic [1:0]  typ;
        logic        conn;
        logic [7:0]  mods, k1, k2, k3, k4, btn, dx, dy;
        logic [9:0]  game;
        logic [63:0] dbg;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_act, mon_exp;
    int         errors = 0;
    int         checks = 0;
    int         strobes = 0;
    int         acks = 0;
    int         cyc = 0;
    int         stb_cyc_last = 0;
    int         stb_cyc_prev = 0;
    logic [1:0] pub_typ = 2'd0;
    logic       pub_conn = 1'b0;

    usb_hid_report_decoder #(
        .LED_TIMEOUT_CYCLES (TMO)
    ) dut (
        .usb_clk             (usb_clk),
        .usb_rst_n           (usb_rst_n),
        .rpt_valid           (rpt_valid),
        .rpt_data            (rpt_data),
        .rpt_last            (rpt_last),
        .rpt_err             (rpt_err),
        .dev_typ             (dev_typ),
        .dev_conn_err        (dev_conn_err),
        .usb_typ             (usb_typ),
        .usb_conn_err        (usb_conn_err),
        .usb_report_stb      (usb_report_stb),
        .usb_key_modifiers   (usb_key_modifiers),
        .usb_key1            (usb_key1),
        .usb_key2            (usb_key2),
        .usb_key3            (usb_key3),
        .usb_key4            (usb_key4),
        .usb_mouse_btn       (usb_mouse_btn),
        .usb_mouse_dx        (usb_mouse_dx),
        .usb_mouse_dy        (usb_mouse_dy),
        .usb_game_l          (usb_game_l),
        .usb_game_r          (usb_game_r),
        .usb_game_u          (usb_game_u),
        .usb_game_d          (usb_game_d),
        .usb_game_a          (usb_game_a),
        .usb_game_b          (usb_game_b),
        .usb_game_x          (usb_game_x),
        .usb_game_y          (usb_game_y),
        .usb_game_sel        (usb_game_sel),
        .usb_game_sta        (usb_game_sta),
        .usb_dbg_hid_report  (usb_dbg_hid_report),
        .update_leds_stb     (update_leds_stb),
        .leds                (leds),
        .led_req             (led_req),
        .led_data            (led_data),
        .led_done            (led_done),
        .ack_update_leds_stb (ack_update_leds_stb)
    );

    always #5 usb_clk = ~usb_clk;

    always @(posedge usb_clk) cyc++;

    // Scoreboard: every strobe must match the oldest expectation.
    always @(negedge usb_clk) begin
        if (usb_rst_n && usb_report_stb) begin
            mon_act      = '0;
            mon_act.typ  = usb_typ;
            mon_act.conn = usb_conn_err;
            mon_act.mods = usb_key_modifiers;
            mon_act.k1   = usb_key1;
            mon_act.k2   = usb_key2;
            mon_act.k3   = usb_key3;
            mon_act.k4   = usb_key4;
            mon_act.btn  = usb_mouse_btn;
            mon_act.dx   = usb_mouse_dx;
            mon_act.dy   = usb_mouse_dy;
            mon_act.game = {usb_game_l, usb_game_r, usb_game_u, usb_game_d, usb_game_a,
                            usb_game_b, usb_game_x, usb_game_y, usb_game_sel, usb_game_sta};
            mon_act.dbg  = usb_dbg_hid_report;
            strobes++;
            stb_cyc_prev = stb_cyc_last;
            stb_cyc_last = cyc;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe: got %h, required no strobe", mon_act);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_act !== mon_exp) begin
                    errors++;
                    $display("FAIL strobe_fields: got %h, required %h", mon_act, mon_exp);
                end else begin
                    $display("strobe typ=%0d conn=%0d dbg=%h", mon_act.typ, mon_act.conn, mon_act.dbg);
                end
            end
        end
        if (usb_rst_n && ack_update_leds_stb) begin
            acks++;
            $display("led ack at cycle %0d, led_data=%h", cyc, led_data);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge usb_clk);
        #1;
    endtask

    function automatic exp_t mk_status(input logic [1:0] t, input logic c);
        exp_t e;
        e      = '0;
        e.typ  = t;
        e.conn = c;
        return e;
    endfunction

    task automatic set_status(input logic [1:0] t, input logic c);
        dev_typ      = t;
        dev_conn_err = c;
        pub_typ      = t;
        pub_conn     = c;
        exp_q.push_back(mk_status(t, c));
    endtask

    task automatic send_report(input logic [63:0] bytes, input int n, input logic with_last,
                               input logic conn_at_last);
        for (int i = 0; i < n; i++) begin
            rpt_valid = 1'b1;
            rpt_data  = bytes[8*i +: 8];
            rpt_last  = with_last && (i == n - 1);
            if (i == n - 1) dev_conn_err = conn_at_last;
            tick();
        end
        rpt_valid = 1'b0;
        rpt_last  = 1'b0;
        rpt_data  = 8'h00;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        repeat (3) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d strobes outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        repeat (3) tick();
        @(negedge usb_clk);
        checks++;
        if (usb_report_stb !== 1'b0) begin errors++; $display("FAIL reset_stb: got %b, required 0", usb_report_stb); end
        checks++;
        if (usb_typ !== 2'd0) begin errors++; $display("FAIL reset_typ: got %0d, required 0", usb_typ); end
        checks++;
        if (usb_dbg_hid_report !== 64'h0) begin errors++; $display("FAIL reset_dbg: got %h, required 0", usb_dbg_hid_report); end
        checks++;
        if (usb_key_modifiers !== 8'h00) begin errors++; $display("FAIL reset_mods: got %h, required 00", usb_key_modifiers); end
        checks++;
        if (led_req !== 1'b0 || led_data !== 8'h00) begin
            errors++; $display("FAIL reset_led: got req=%b data=%h, required 0/00", led_req, led_data);
        end
        checks++;
        if (ack_update_leds_stb !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b, required 0", ack_update_leds_stb); end
        // Leaving reset with dev_typ=1 differs from the cleared status, so a status strobe follows.
        tick();
        set_status(2'd1, 1'b0);
        usb_rst_n = 1'b1;
        drain("reset_status");
    endtask

    task automatic test_keyboard();
        exp_t e;
        e = mk_status(pub_typ, pub_conn);
        e.mods = 8'h02; e.k1 = 8'h04; e.k2 = 8'h05;
        e.dbg  = 64'h0000_0000_0504_0002;
        exp_q.push_back(e);
        send_report(64'h0000_0000_0504_0002, 8, 1'b1, dev_conn_err);
        drain("keyboard");
        repeat (4) tick();
        checks++;
        if (usb_key2 !== 8'h05) begin errors++; $display("FAIL keyboard_hold: got %h, required 05", usb_key2); end
    endtask

    task automatic test_mouse();
        exp_t e;
        set_status(2'd2, dev_conn_err);
        drain("mouse_status");
        e = mk_status(pub_typ, pub_conn);
        e.btn = 8'h01; e.dx = 8'hFB; e.dy = 8'h03;
        e.dbg = 64'h0000_0000_0003_FB01;
        exp_q.push_back(e);
        send_report(64'h0000_0000_0003_FB01, 3, 1'b1, dev_conn_err);
        drain("mouse");
        // Two-byte mouse report is below the minimum length: discarded, no strobe.
        send_report(64'h0000_0000_0000_7702, 2, 1'b1, dev_conn_err);
        drain("mouse_short");
        checks++;
        if (usb_mouse_dx !== -8'sd5 || usb_mouse_btn !== 8'h01) begin
            errors++; $display("FAIL mouse_short_hold: got btn=%h dx=%0d, required 01/-5", usb_mouse_btn, usb_mouse_dx);
        end
        checks++;
        if (usb_dbg_hid_report !== 64'h0000_0000_0003_FB01) begin
            errors++; $display("FAIL mouse_short_dbg: got %h, required 000000000003fb01", usb_dbg_hid_report);
        end
    endtask

    task automatic test_gamepad();
        exp_t e;
        set_status(2'd3, dev_conn_err);
        drain("gamepad_status");
`ifdef USB_HID_GAMEPAD_EN
        e = mk_status(pub_typ, pub_conn);
        e.game = 10'b1001_1100_01;
        e.dbg  = 64'h0020_3000_0000_FF00;
        exp_q.push_back(e);
`else
        e = '0;
`endif
        send_report(64'h0020_3000_0000_FF00, 7, 1'b1, dev_conn_err);
        drain("gamepad");
        checks++;
        if (usb_game_d !== e.game[6] || usb_game_sta !== e.game[0]) begin
            errors++; $display("FAIL gamepad_bits: got d=%b sta=%b, required %b/%b", usb_game_d, usb_game_sta, e.game[6], e.game[0]);
        end
    endtask

    task automatic test_abort();
        exp_t e;
        int   s0;
        set_status(2'd1, dev_conn_err);
        drain("abort_status");
        s0 = strobes;
        send_report(64'h0011_FFEE_DDCC_BBAA, 7, 1'b0, dev_conn_err);
        rpt_err = 1'b1;
        tick();
        rpt_err = 1'b0;
        tick();
        e = mk_status(pub_typ, pub_conn);
        e.k1 = 8'h1E; e.k2 = 8'h1F; e.k3 = 8'h20; e.k4 = 8'h21;
        e.dbg = 64'h0000_2120_1F1E_0000;
        exp_q.push_back(e);
        send_report(64'h0000_2120_1F1E_0000, 6, 1'b1, dev_conn_err);
        drain("abort");
        checks++;
        if (strobes - s0 !== 1) begin errors++; $display("FAIL abort_count: got %0d strobes, required 1", strobes - s0); end
    endtask

    task automatic test_status();
        exp_t e;
        set_status(pub_typ, 1'b1);
        drain("conn_err");
        // Report and status change share a cycle: report strobe first, status on the next cycle.
        e = mk_status(pub_typ, pub_conn);
        e.mods = 8'h01; e.k1 = 8'h2A;
        e.dbg = 64'h0000_0000_002A_0001;
        exp_q.push_back(e);
        pub_conn = 1'b0;
        exp_q.push_back(mk_status(pub_typ, 1'b0));
        send_report(64'h0000_0000_002A_0001, 6, 1'b1, 1'b0);
        drain("report_then_status");
        checks++;
        if (stb_cyc_last - stb_cyc_prev !== 1) begin
            errors++; $display("FAIL status_follow_gap: got %0d cycles, required 1", stb_cyc_last - stb_cyc_prev);
        end
    endtask

    task automatic pulse_led(input logic [3:0] v, input logic done);
        update_leds_stb = 1'b1;
        leds            = v;
        led_done        = done;
        tick();
        update_leds_stb = 1'b0;
        led_done        = 1'b0;
    endtask

    task automatic pulse_done();
        led_done = 1'b1;
        tick();
        led_done = 1'b0;
    endtask

    task automatic test_led();
        int a0;
        int k_ack;
        a0 = acks;
        pulse_led(4'h5, 1'b0);
        @(negedge usb_clk);
        checks++;
        if (led_req !== 1'b1 || led_data !== 8'h05) begin
            errors++; $display("FAIL led_req_set: got req=%b data=%h, required 1/05", led_req, led_data);
        end
        repeat (9) tick();
        pulse_done();
        @(negedge usb_clk);
        checks++;
        if (led_req !== 1'b0 || ack_update_leds_stb !== 1'b1) begin
            errors++; $display("FAIL led_done_ack: got req=%b ack=%b, required 0/1", led_req, ack_update_leds_stb);
        end
        repeat (3) tick();
        checks++;
        if (acks - a0 !== 1) begin errors++; $display("FAIL led_done_count: got %0d acks, required 1", acks - a0); end

        a0 = acks;
        pulse_led(4'hA, 1'b0);
        repeat (3) tick();
        pulse_led(4'h2, 1'b0);
        @(negedge usb_clk);
        checks++;
        if (led_req !== 1'b1 || led_data !== 8'h02) begin
            errors++; $display("FAIL led_coalesce_data: got req=%b data=%h, required 1/02", led_req, led_data);
        end
        repeat (2) tick();
        pulse_done();
        repeat (3) tick();
        checks++;
        if (acks - a0 !== 1) begin errors++; $display("FAIL led_coalesce_count: got %0d acks, required 1", acks - a0); end

        pulse_led(4'h4, 1'b0);
        repeat (2) tick();
        pulse_led(4'hB, 1'b1);
        @(negedge usb_clk);
        checks++;
        if (ack_update_leds_stb !== 1'b1 || led_req !== 1'b1 || led_data !== 8'h0B) begin
            errors++; $display("FAIL led_done_with_stb: got ack=%b req=%b data=%h, required 1/1/0b", ack_update_leds_stb, led_req, led_data);
        end
        tick();
        pulse_done();
        repeat (3) tick();

        pulse_led(4'h7, 1'b0);
        k_ack = 0;
        for (int k = 1; k <= 40 && k_ack == 0; k++) begin
            @(negedge usb_clk);
            if (ack_update_leds_stb) k_ack = k;
            else @(posedge usb_clk);
        end
        checks++;
        if (k_ack !== 17) begin errors++; $display("FAIL led_timeout_cycle: got %0d, required 17", k_ack); end
        tick();
        checks++;
        if (led_req !== 1'b0) begin errors++; $display("FAIL led_timeout_req: got %b, required 0", led_req); end

        set_status(2'd2, dev_conn_err);
        pulse_led(4'h3, 1'b0);
        @(negedge usb_clk);
        checks++;
        if (ack_update_leds_stb !== 1'b1 || led_req !== 1'b0) begin
            errors++; $display("FAIL led_non_keyboard: got ack=%b req=%b, required 1/0", ack_update_leds_stb, led_req);
        end
        drain("led_status");
    endtask

    initial begin
        test_reset();
        test_keyboard();
        test_mouse();
        test_gamepad();
        test_abort();
        test_status();
        test_led();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/usb_hid_report_decoder.md
# usb_hid_report_decoder

Sits directly upstream of the Wishbone USB HID register block, in the USB clock domain. Collects the raw IN-report byte stream from the USB HID host core, decodes it according to the enumerated device type (keyboard, mouse, gamepad), and publishes decoded fields with a one-cycle report strobe. It also turns the register block's LED-update strobe into a held request/done handshake with the host core, and returns the acknowledge strobe.

## Interface
- LED_TIMEOUT_CYCLES, 24'd12_000_000: cycles to wait for `led_done` before abandoning an LED request (1 s at 12 MHz).
- usb_clk  in  1  clock
- usb_rst_n  in  1  reset, synchronous, active-low
- rpt_valid  in  1  report byte valid; no backpressure
- rpt_data  in  8  report byte
- rpt_last  in  1  qualifies the final byte of a report (with rpt_valid)
- rpt_err  in  1  single-cycle abort of the report in progress
- dev_typ  in  2  enumerated type: 0 none, 1 keyboard, 2 mouse, 3 gamepad
- dev_conn_err  in  1  host core connection error level
- usb_typ, usb_conn_err  out  2, 1  published status
- usb_report_stb  out  1  one-cycle publish strobe
- usb_key_modifiers, usb_key1..usb_key4  out  8 each  keyboard fields
- usb_mouse_btn  out  8; usb_mouse_dx, usb_mouse_dy  out  8 signed
- usb_game_l/r/u/d/a/b/x/y/sel/sta  out  1 each
- usb_dbg_hid_report  out  64  first 8 bytes of the report; byte i at [8i+7:8i]
- update_leds_stb  in  1; leds  in  4  LED request from the register block
- led_req  out  1; led_data  out  8  request to the host core; led_data = {4'b0, leds}
- led_done  in  1  host core completed the SET_REPORT
- ack_update_leds_stb  out  1  one-cycle completion pulse

## Operation
- Report FSM: IDLE -> RECV on the first rpt_valid. A single-byte report with rpt_last goes straight to PUBLISH. RECV -> PUBLISH on rpt_valid&rpt_last. RECV -> IDLE on rpt_err, discarding the report.
- Byte index is 4 bits and saturates at 8. Bytes 0..7 are written into the 64-bit buffer; bytes beyond 8 are ignored. The buffer is zeroed on entry to RECV.
- PUBLISH lasts one cycle, then returns to IDLE. A byte arriving during PUBLISH starts a new report (index 0).
- Minimum lengths: keyboard 6, mouse 3, gamepad 7. A shorter report, or dev_typ=0, is discarded with no strobe.
- Keyboard decode: modifiers=b0, key1..4=b2..b5.
- Mouse decode: btn=b0, dx=b1, dy=b2, all raw.
- Gamepad decode:
  - l = b0<8'h40, r = b0>8'hBF, u = b1<8'h40, d = b1>8'hBF (unsigned compares).
  - a,b,x,y = b5[4..7]; sel = b6[4]; sta = b6[5].
- Fields not belonging to the current type are driven 0.
- Status publish: when {dev_typ, dev_conn_err} differs from {usb_typ, usb_conn_err} and the FSM is IDLE, publish a strobe with all report fields and debug zeroed. A report publish in the same cycle takes priority; the status publish follows on the next IDLE cycle.
- LED handshake:
  - update_leds_stb sets led_req, loads led_data and clears the timeout counter.
  - A new update_leds_stb while pending overwrites led_data and produces only one ack (coalesced). The host core latches led_data at transaction start.
  - On led_done, or when the counter reaches LED_TIMEOUT_CYCLES-1: clear led_req and pulse ack_update_leds_stb.
  - If dev_typ≠1 at update_leds_stb: no request is raised; ack pulses the next cycle.
  - update_leds_stb in the same cycle as led_done: ack pulses, led_req stays 1 with the new data, and the counter restarts.

## Timing
- Reset: all outputs 0, FSM IDLE, counter 0.
- usb_rst_n asserted mid-report or mid-LED-request drops everything silently; no ack.
- Last byte sampled at cycle N -> fields and usb_report_stb valid at N+1. Fields hold until the next publish.
- update_leds_stb at N -> led_req=1 at N+1.
- led_done at N -> led_req=0 and ack=1 at N+1.
- Timeout ack occurs LED_TIMEOUT_CYCLES+1 cycles after the strobe.

## Configuration
- USB_HID_GAMEPAD_EN defined: gamepad decode is present.
- Undefined: usb_game_* tied 0 and type-3 reports are discarded. Status publishes still carry usb_typ=3.

## Structure
- Package usb_hid_pkg holds:
  - the dev_typ enum (NONE, KEYBOARD, MOUSE, GAMEPAD);
  - per-type minimum lengths and gamepad byte/bit offsets;
  - axis thresholds 8'h40/8'hBF;
  - the FSM state enum.
- Sub-module usb_hid_led_req contains the LED request/done/timeout handshake.

## Test plan
- Keyboard (dev_typ=1), bytes 02 00 04 05 00 00 00 00 with last -> one strobe; modifiers=02, key1=04, key2=05, dbg=64'h0000_0000_0504_0002.
- Mouse, 3 bytes 01 FB 03 -> btn=01, dx=-5, dy=3. Same report cut to 2 bytes -> no strobe, fields unchanged.
- Gamepad, b0=00, b1=FF, b5=30, b6=20 -> l=1, d=1, a=1, b=1, sta=1, others 0. With USB_HID_GAMEPAD_EN undefined -> no strobe.
- rpt_err after 3 keyboard bytes, then a full valid report -> exactly one strobe, carrying the second report's data.
- dev_conn_err 0->1 while IDLE -> strobe with usb_conn_err=1 and all fields 0. Same change arriving with a final byte -> report strobe first, status strobe next cycle.
- LED: update_leds_stb leds=4'h5, led_done 10 cycles later -> led_data=05, one ack. Second strobe leds=4'h2 while pending -> led_data=02, one ack. No led_done with LED_TIMEOUT_CYCLES=16 -> ack at cycle 17.
